uart_tx_ctrl: RTL and testbench

Transmit sequencer for the UART 16550 path. It drains the 16-entry TX FIFO one byte per frame and serialises each byte onto the tx line. A frame is a start bit, 5-8 data bits (LSB first), an optional parity bit and 1, 1.5 or 2 stop bits, all timed by the 16x baud pulse. It owns the FIFO pop handshake and reports transmitter status for the LSR/interrupt logic.

---
 rtl/uart_pkg.sv | 59 +++++
 rtl/uart_tx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types, constants and helper functions for the UART transmit path.
//   tx_state_t          : transmit sequencer states
//   WLS_5 .. WLS_8      : word length select encodings (5..8 data bits)
//   OVERSAMPLE_DEFAULT  : baud_tick pulses per bit period
//   calc_parity()       : parity bit over the transmitted data bits only
//   stop_ticks()        : stop duration in baud_ticks (1, 1.5 or 2 bits)
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] WLS_5 = 2'd0;
    localparam logic [1:0] WLS_6 = 2'd1;
    localparam logic [1:0] WLS_7 = 2'd2;
    localparam logic [1:0] WLS_8 = 2'd3;

    localparam int OVERSAMPLE_DEFAULT = 16;

    // Bits above the selected word length never reach the line, so they are
    // masked out before the XOR. Stick parity ignores the data entirely.
    function automatic logic calc_parity(input logic [7:0] data,
                                         input logic [1:0] wls,
                                         input logic       eps,
                                         input logic       sp);
        logic [7:0] mask;
        logic       x;
        mask = 8'hFF >> (3'd3 - {1'b0, wls});
        x    = ^(data & mask);
        if (sp) begin
            return ~eps;
        end else if (eps) begin
            return x;
        end else begin
            return ~x;
        end
    endfunction

    // 1.5 stop bits only exist for 5-bit words; otherwise stb selects 2.
    function automatic int unsigned stop_ticks(input logic [1:0]  wls,
                                               input logic        stb,
                                               input int unsigned os);
        if (!stb) begin
            return os;
        end else if (wls == WLS_5) begin
            return os + os / 2;
        end else begin
            return 2 * os;
        end
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Transmit sequencer: pops one byte per frame from the TX FIFO and shifts it
// out as start / 5-8 data bits (LSB first) / optional parity / stop bits,
// every bit timed by the 16x baud pulse.
//
// Ports
//   clk, rst     : clock; asynchronous active-high reset
//   en           : transmitter enable, only gates the start of a new frame
//   baud_tick    : one-clk pulse at OVERSAMPLE x baud
//   fifo_empty   : TX FIFO empty flag
//   fifo_dout    : TX FIFO head word (valid while !fifo_empty)
//   fifo_pop     : one-clk pop strobe, asserted in the load cycle
//   wls,stb,pen,eps,sp : line control; sampled once per frame at load
//   set_break    : forces tx low without disturbing the sequencer
//   tx           : registered serial output
//   tx_busy      : frame in progress
//   temt         : FIFO empty and sequencer idle
//
// FIFO handshake: fifo_pop is asserted only in a cycle where fifo_empty=0,
// and the head word on fifo_dout is captured on the same clock edge that
// the FIFO retires it.
// ---------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              baud_tick,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_pop,
    input  logic [1:0]        wls,
    input  logic              stb,
    input  logic              pen,
    input  logic              eps,
    input  logic              sp,
    input  logic              set_break,
    output logic              tx,
    output logic              tx_busy,
    output logic              temt
);

    // Wide enough to count the longest stop period (2 bit times).
    localparam int             TW       = $clog2(2 * OVERSAMPLE + 1);
    localparam logic [TW-1:0]  BIT_LAST = TW'(OVERSAMPLE - 1);

    tx_state_t          state;
    tx_state_t          state_nxt;
    logic [TW-1:0]      tick_cnt;
    logic [TW-1:0]      stop_last;
    logic [2:0]         bit_cnt;
    logic [DATA_W-1:0]  shift;
    logic [1:0]         cfg_wls;
    logic               cfg_pen;
    logic               par_bit;

    logic               can_load;
    logic               bit_end;
    logic               stop_end;
    logic               last_bit;
    logic               load;
    logic               fsm_tx;

    assign can_load = en && !fifo_empty;
    assign bit_end  = baud_tick && (tick_cnt == BIT_LAST);
    assign stop_end = baud_tick && (tick_cnt == stop_last);
    assign last_bit = (bit_cnt == ({1'b0, cfg_wls} + 3'd4));

    // A frame is loaded either from idle or directly at the end of the
    // previous stop period, so back-to-back frames have no idle gap.
    assign load = can_load && ((state == ST_IDLE) ||
                               ((state == ST_STOP) && stop_end));

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (can_load) state_nxt = ST_START;
            end
            ST_START: begin
                if (bit_end) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && last_bit) state_nxt = cfg_pen ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_end) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (stop_end) state_nxt = can_load ? ST_START : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        fsm_tx  = 1'b1;
        tx_busy = (state != ST_IDLE);
        temt    = fifo_empty && (state == ST_IDLE);
        // Gated by rst so no pop leaks out while reset holds the FSM in IDLE.
        fifo_pop = load && !rst;
        case (state)
            ST_START:  fsm_tx = 1'b0;
            ST_DATA:   fsm_tx = shift[0];
            ST_PARITY: fsm_tx = par_bit;
            default:   fsm_tx = 1'b1;
        endcase
    end

    // ---------------- counters and frame datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt  <= '0;
            stop_last <= '0;
            bit_cnt   <= 3'd0;
            shift     <= '0;
            cfg_wls   <= WLS_5;
            cfg_pen   <= 1'b0;
            par_bit   <= 1'b0;
        end else if (load) begin
            // A baud_tick coinciding with the load cycle is deliberately dropped.
            tick_cnt  <= '0;
            bit_cnt   <= 3'd0;
            shift     <= fifo_dout;
            cfg_wls   <= wls;
            cfg_pen   <= pen;
            par_bit   <= calc_parity(8'(fifo_dout), wls, eps, sp);
            stop_last <= TW'(stop_ticks(wls, stb, OVERSAMPLE) - 1);
        end else if ((state != ST_IDLE) && baud_tick) begin
            if ((state == ST_STOP) ? stop_end : bit_end) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
            if ((state == ST_DATA) && bit_end) begin
                shift   <= shift >> 1;
                bit_cnt <= last_bit ? 3'd0 : bit_cnt + 3'd1;
            end
        end
    end

    // ---------------- registered line output ----------------
    // The line follows the state one clk late; break overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx <= 1'b1;
        end else begin
            tx <= set_break ? 1'b0 : fsm_tx;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Directed bench for uart_tx_ctrl. A small queue models the TX FIFO, the
// line is sampled once per consumed baud_tick and compared with a per-tick
// expected stream built from hand-derived frame contents.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic       baud_tick;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_pop;
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
    logic       set_break;
    logic       tx;
    logic       tx_busy;
    logic       temt;

    uart_tx_ctrl #(.OVERSAMPLE(16), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .baud_tick  (baud_tick),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_pop   (fifo_pop),
        .wls        (wls),
        .stb        (stb),
        .pen        (pen),
        .eps        (eps),
        .sp         (sp),
        .set_break  (set_break),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .temt       (temt)
    );

    // baud_tick: one-clk pulse every second clk, changed just after posedge
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1 baud_tick = ~baud_tick;
        end
    end

    // ---------------- bookkeeping ----------------
    logic [7:0] fifo_q[$];
    logic [0:0] exp_q[$];
    int n_checks   = 0;
    int n_errors   = 0;
    int samples    = 0;
    int extra      = 0;
    int pops       = 0;
    int bad_pops   = 0;
    int busy_falls = 0;
    logic busy_prev  = 1'b0;
    logic pop_pend   = 1'b0;
    logic tick_taken = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void fifo_refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? 8'h00 : fifo_q[0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_refresh();
    endtask

    // Expected line level for every consumed baud_tick of one frame.
    task automatic add_frame(input logic [7:0] data, input int nbits, input int par, input int stop_t);
        repeat (16) exp_q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            repeat (16) exp_q.push_back(data[i]);
        end
        if (par >= 0) begin
            repeat (16) exp_q.push_back(par[0]);
        end
        repeat (stop_t) exp_q.push_back(1'b1);
    endtask

    task automatic wait_busy(input string tag);
        int c = 0;
        while (!tx_busy && c < 50) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_start"}, tx_busy, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        while (tx_busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_end"}, tx_busy, 0);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_samples(input string tag, input int n);
        int c = 0;
        while (samples < n && c < 2000) begin
            @(posedge clk);
            c++;
        end
        check({tag, "_reach"}, (samples >= n), 1);
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic s, input logic p, input logic e, input logic stick);
        wls = w; stb = s; pen = p; eps = e; sp = stick;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] data, input logic [1:0] w,
                             input logic s, input logic p, input logic e, input logic stick,
                             input int par_exp, input int stop_t, input int exp_ticks,
                             input bit cfg_flip);
        int pops0;
        int falls0;
        @(negedge clk);
        set_cfg(w, s, p, e, stick);
        en = 1'b1;
        samples = 0; extra = 0;
        pops0 = pops; falls0 = busy_falls;
        add_frame(data, int'(w) + 5, par_exp, stop_t);
        push(data);
        wait_busy(tag);
        if (cfg_flip) begin
            // Line control and enable changes must not disturb the running frame.
            set_cfg(~w, ~s, ~p, ~e, stick);
            en = 1'b0;
        end
        wait_idle(tag, 2000);
        check({tag, "_ticks"}, samples, exp_ticks);
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_pops"}, pops - pops0, 1);
        check({tag, "_falls"}, busy_falls - falls0, 1);
        check({tag, "_temt"}, temt, 1);
        check({tag, "_txidle"}, tx, 1);
    endtask

    // ---------------- FIFO model and scoreboard ----------------
    always @(posedge clk) begin
        pop_pend   <= fifo_pop;
        tick_taken <= baud_tick && tx_busy;
    end

    always @(negedge clk) begin
        logic [7:0] tmp;
        logic [0:0] e;
        if (pop_pend) begin
            pops++;
            if (fifo_q.size() > 0) tmp = fifo_q.pop_front();
            fifo_refresh();
        end
        if (fifo_pop && fifo_empty) bad_pops++;
        if (busy_prev && !tx_busy) busy_falls++;
        busy_prev = tx_busy;
        if (tick_taken) begin
            samples++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (set_break) check("tx_bit", tx, 0);
                else           check("tx_bit", tx, e);
            end else begin
                extra++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int pops0;
        int falls0;
        rst = 1'b1; en = 1'b0; set_break = 1'b0;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        fifo_refresh();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_pop", fifo_pop, 0);
        check("rst_temt", temt, 1);
        en = 1'b1;
        push(8'h11);
        @(negedge clk);
        check("rst_pop_nonempty", fifo_pop, 0);
        check("rst_temt_nonempty", temt, 0);

        // Released with en=0: nothing may start
        en = 1'b0;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("en_off_busy", tx_busy, 0);
        check("en_off_pops", pops, 0);
        check("en_off_temt", temt, 0);
        fifo_q.delete();
        fifo_refresh();

        // Single frames: data, parity kinds, stop lengths
        run_frame("f8n1_55", 8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, -1, 16, 160, 1'b0);
        run_frame("f7e1_41", 8'h41, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0,  0, 16, 160, 1'b1);
        run_frame("f5n15_1f", 8'h1F, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, -1, 24, 120, 1'b0);
        run_frame("f8n2_1f", 8'h1F, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, -1, 32, 176, 1'b0);
        run_frame("f8o1_03", 8'h03, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0,  1, 16, 176, 1'b0);
        run_frame("f8s1_01", 8'h01, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1,  0, 16, 176, 1'b0);
        run_frame("f6e1_7e", 8'h7E, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0,  1, 16, 144, 1'b0);

        // Back-to-back frames: no idle gap between them
        @(negedge clk);
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        samples = 0; pops0 = pops; falls0 = busy_falls;
        add_frame(8'hA5, 8, -1, 16);
        add_frame(8'h3C, 8, -1, 16);
        push(8'hA5);
        push(8'h3C);
        wait_busy("b2b");
        wait_idle("b2b", 4000);
        check("b2b_ticks", samples, 320);
        check("b2b_left", exp_q.size(), 0);
        check("b2b_pops", pops - pops0, 2);
        check("b2b_falls", busy_falls - falls0, 1);

        // Break asserted during data bits of 0xFF
        @(negedge clk);
        samples = 0; pops0 = pops; falls0 = busy_falls;
        add_frame(8'hFF, 8, -1, 16);
        push(8'hFF);
        wait_busy("brk");
        wait_samples("brk_on", 48);
        #1 set_break = 1'b1;
        wait_samples("brk_off", 96);
        #1 set_break = 1'b0;
        wait_idle("brk", 2000);
        check("brk_ticks", samples, 160);
        check("brk_left", exp_q.size(), 0);
        check("brk_pops", pops - pops0, 1);
        check("brk_falls", busy_falls - falls0, 1);

        // Reset in the middle of data bit 3 of 0x0F
        @(negedge clk);
        samples = 0;
        add_frame(8'h0F, 8, -1, 16);
        push(8'h0F);
        wait_busy("mrst");
        wait_samples("mrst_bit3", 72);
        #3 rst = 1'b1;
        #1;
        check("mrst_tx", tx, 1);
        check("mrst_busy", tx_busy, 0);
        check("mrst_pop", fifo_pop, 0);
        exp_q.delete();
        push(8'h33);
        @(negedge clk);
        #1;
        check("mrst_pop_nonempty", fifo_pop, 0);
        check("mrst_temt", temt, 0);
        @(negedge clk);
        samples = 0; extra = 0; pops0 = pops; falls0 = busy_falls;
        add_frame(8'h33, 8, -1, 16);
        rst = 1'b0;
        wait_busy("mrst_next");
        wait_idle("mrst_next", 2000);
        check("mrst_next_ticks", samples, 160);
        check("mrst_next_left", exp_q.size(), 0);
        check("mrst_next_pops", pops - pops0, 1);

        check("pop_while_empty", bad_pops, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
